// File: rtl/mmm_pe_scheduler_if.sv
// mmm_pe_scheduler_if: start/operand handshake and PE-array control bundle for the Montgomery PE sequencer
interface mmm_pe_scheduler_if #(
  parameter int N = 12,
  parameter int W = 3
);
  localparam int E = (N + W) / W;
  logic start;
  logic [N-1:0] x_in;
  logic y0;
  logic s_lsb;
  logic busy;
  logic done;
  logic pe_clr;
  logic [E-1:0] pe_en;
  logic [E-1:0] pe_xi;
  logic [E-1:0] pe_c;
  logic [$clog2(N)-1:0] iter;
  modport master (
    output start, x_in, y0, s_lsb,
    input busy, done, pe_clr, pe_en, pe_xi, pe_c, iter
  );
  modport slave (
    input start, x_in, y0, s_lsb,
    output busy, done, pe_clr, pe_en, pe_xi, pe_c, iter
  );
endinterface

// File: rtl/mmm_pe_scheduler.sv
// mmm_pe_scheduler: issues one Montgomery iteration every 2 cycles into stage 0 and skews en/xi/c diagonally across the PE array
module mmm_pe_scheduler #(
  parameter int N = 12,
  parameter int W = 3
) (
  input logic clk,
  input logic rst,
  mmm_pe_scheduler_if.slave bus
);
  localparam int E = (N + W) / W;
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(2 * N + E);
  localparam logic [TW-1:0] T_LAST = TW'(2 * N + E - 3);
  localparam logic [TW-2:0] K_LAST = (TW - 1)'(N - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t state;
  logic [TW-1:0] t;
  logic [TW-2:0] k;
  logic [N-1:0] x_sh;
  logic [E-1:1] en_d;
  logic [E-1:1] xi_d;
  logic [E-1:1] c_d;
  logic [E-1:0] pe_en;
  logic [E-1:0] pe_xi;
  logic [E-1:0] pe_c;
  logic busy;
  logic done;
  logic pe_clr;
  logic en0;
  logic xi0;
  logic c0;
  assign k = t[TW-1:1];
  assign en0 = state == RUN && !t[0] && k <= K_LAST;
  assign xi0 = en0 & x_sh[0];
  assign c0 = en0 & (bus.s_lsb ^ (x_sh[0] & bus.y0));
  assign pe_en = {en_d, en0};
  assign pe_xi = {xi_d, xi0};
  assign pe_c = {c_d, c0};
  assign bus.pe_en = pe_en;
  assign bus.pe_xi = pe_xi;
  assign bus.pe_c = pe_c;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.pe_clr = pe_clr;
  assign bus.iter = k >= K_LAST ? IW'(N - 1) : k[IW-1:0];
  // sequencer: accept, clear the array, run 2N-2+E cycles, pulse done; x shifts out LSB first per issue
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pe_clr <= 1'b1;
      t <= '0;
      x_sh <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= bus.start ? CLEAR : IDLE;
          busy <= bus.start;
          pe_clr <= bus.start;
          if (bus.start) x_sh <= bus.x_in;
        end
        CLEAR: begin
          state <= RUN;
          pe_clr <= 1'b0;
        end
        RUN: begin
          t <= t + TW'(1);
          if (en0) x_sh <= x_sh >> 1;
          if (t == T_LAST) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
          t <= '0;
        end
      endcase
    end
  // diagonal skew: stage j sees stage 0's en/xi/c exactly j cycles later
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      en_d <= '0;
      xi_d <= '0;
      c_d <= '0;
    end else begin
      en_d <= pe_en[E-2:0];
      xi_d <= pe_xi[E-2:0];
      c_d <= pe_c[E-2:0];
    end
endmodule

// File: doc/mmm_pe_scheduler.md
Name: mmm_pe_scheduler

Overview:
- Sequencer for the linear array of radix-2 Montgomery processing elements. Each PE handles one W-bit word of Y, M and S.
- Accepts a start request and latches the multiplier operand X. Clears the array, then issues one Montgomery iteration (one bit xi of X) every 2 cycles into stage 0.
- Skews enable, xi and quotient bit c diagonally across the stages, one cycle per stage, and signals done when the last stage has finished the last iteration.
- Sits between the top-level multiplier wrapper and the PE array.

Parameters:
- N, 12, operand width in bits (number of iterations).
- W, 3, PE word width in bits.
- E, derived localparam ceil((N+1)/W) (5 for defaults), number of PE stages.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a multiplication. Sampled only in IDLE.
- x_in  input  N  multiplier operand X. Latched in the cycle start is accepted.
- y0  input  1  bit 0 of operand Y.
- s_lsb  input  1  bit 0 of the running sum presented to stage 0 (stage 0 S1_old[0]).
- busy  output  1  high from the start-accept cycle until done.
- done  output  1  one-cycle pulse when the result in the array is complete.
- pe_clr  output  1  synchronous, active-high clear to all PEs.
- pe_en  output  E  per-stage enable.
- pe_xi  output  E  per-stage xi.
- pe_c  output  E  per-stage quotient bit c.
- iter  output  clog2(N)  index of the iteration currently at stage 0.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - busy, done, pe_en, pe_xi, pe_c, iter and the internal counters are all 0.
  - pe_clr is 1 while in reset and for the first cycle after reset release.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start=1 latches x_in into x_reg, sets busy=1 and goes to CLEAR.
  - start=0 keeps the state in IDLE.
- CLEAR (exactly 1 cycle): pe_clr=1 and pe_en=0. Then go to RUN with cycle counter t=0.
- RUN, with t counting 0 to 2N-2+E-1:
  - pe_en[j]=1 iff (t-j) >= 0, (t-j) is even and k=(t-j)/2 <= N-1.
  - When pe_en[j]=1: pe_xi[j]=x_reg[k] and pe_c[j]=c_k.
  - When pe_en[j]=0: pe_xi[j]=0 and pe_c[j]=0.
- Quotient bit:
  - Computed at stage 0 when stage 0 is enabled: c_k = s_lsb XOR (x_reg[k] AND y0).
  - It is combinational onto pe_c[0] and registered into a skew line.
  - Stage j receives c_k exactly j cycles later; pe_xi uses the same skew line.
- iter = k for stage 0, held between issues, saturating at N-1.
- Stage-0 issue spacing is fixed at 2 cycles, because the word-carry dependency between adjacent PEs requires it.
- Total RUN length is 2N-2+E cycles (27 for defaults). The last assertion is pe_en[E-1] at t=2N-2+E-1.
- DONE (1 cycle): done=1, busy is still 1, all pe_en=0. Next cycle go to IDLE with busy=0.
- start is ignored in every state except IDLE. No queueing.
- start asserted in the DONE cycle is ignored. start is accepted from the following IDLE cycle. Back-to-back throughput is one operation per 2N+E+1 cycles.
- x_in changes after acceptance have no effect.
- Reset mid-operation aborts immediately: no done pulse, and pe_clr follows the reset rule above.

Test Plan:
- Reset release, start=0 for 10 cycles -> pe_clr=1 for exactly 1 cycle after release; busy, done and pe_en stay 0.
- Defaults, x_in=12'hA5C, y0=1, s_lsb=0, start pulse in IDLE -> busy rises next edge.
  - One cycle later pe_clr=1 with pe_en=0.
  - Then pe_en[0] pulses at t=0,2,...,22 with pe_xi[0]=0,0,1,1,1,0,1,0,0,1,0,1 (LSB first).
  - pe_en[4] pulses at t=4,...,26.
  - done pulses 28 cycles after CLEAR.
- Same run with s_lsb tied 1 and y0=1 -> pe_c[0] = NOT xi each issue; pe_c[3] equals pe_c[0] delayed 3 cycles.
- start held high continuously -> operations repeat every 30 cycles. Exactly one done pulse per operation; start in the DONE cycle is not taken.
- start re-pulsed at t=7 with a different x_in -> ignored; the pe_xi sequence still follows the first operand.
- rst asserted at t=10 of RUN -> pe_en, busy and done go to 0 immediately. No done pulse. Normal operation after release.
